// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared definitions for bit-serial ALU blocks
// Purpose: FSM state encoding and the counter-width helper for serial datapaths.
// Ports: none (package).
package serial_sub_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  // Bits needed to count 0..n-1; never returns less than 1 so a
  // two-bit operand still gets a usable counter.
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    for (int i = 0; i < 31; i++) begin
      if ((1 << w) < n) w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/serial_subtractor_fs.sv
// rtl/serial_subtractor_fs.sv - half and full subtractor cells
// Purpose: one-bit subtract cells used by the serial subtract engine.
// Ports (half_subtractor): x, y in; diff = x^y, bout = ~x&y out.
// Ports (full_subtractor): x, y, bin in; diff = x^y^bin, bout = borrow out.
module half_subtractor (
  input  logic x,
  input  logic y,
  output logic diff,
  output logic bout
);

  assign diff = x ^ y;
  assign bout = ~x & y;

endmodule

module full_subtractor (
  output logic diff,
  output logic bout,
  input  logic x,
  input  logic y,
  input  logic bin
);

  logic d1;
  logic b1;
  logic b2;

  half_subtractor u_hs0 (
    .x    (x),
    .y    (y),
    .diff (d1),
    .bout (b1)
  );

  // Second stage borrows only when x==y, giving ~(x^y)&bin.
  half_subtractor u_hs1 (
    .x    (d1),
    .y    (bin),
    .diff (diff),
    .bout (b2)
  );

  assign bout = b1 | b2;

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial A - B - bin engine, LSB first
// Purpose: accepts operands on start while ready, resolves one bit per clock
//   through a single full_subtractor, then presents diff/bout with a done pulse.
// Ports: clk, rst_n (async active-low); start, a, b, bin in;
//   ready, busy, done, diff, bout out (all registered or decoded from state).
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q,  state_d;
  logic [WIDTH-1:0] a_sr_q,   a_sr_d;
  logic [WIDTH-1:0] b_sr_q,   b_sr_d;
  logic [WIDTH-1:0] res_sr_q, res_sr_d;
  logic             brw_q,    brw_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic [WIDTH-1:0] diff_q,   diff_d;
  logic             bout_q,   bout_d;
  logic             done_q,   done_d;

  logic cell_d;
  logic cell_bo;

  full_subtractor u_fs (
    .diff (cell_d),
    .bout (cell_bo),
    .x    (a_sr_q[0]),
    .y    (b_sr_q[0]),
    .bin  (brw_q)
  );

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    brw_d    = brw_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          brw_d   = bin;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        // New bit enters at the MSB so after WIDTH shifts bit 0 is the LSB result.
        res_sr_d = (res_sr_q >> 1) | {cell_d, {(WIDTH-1){1'b0}}};
        brw_d    = cell_bo;
        if (cnt_q == CNT_LAST) begin
          // Result is committed only here so diff/bout stay stable during RUN.
          diff_d  = res_sr_d;
          bout_d  = cell_bo;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      brw_q    <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      brw_q    <= brw_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      done_q   <= done_d;
    end
  end

  assign ready = (state_q == S_IDLE);
  assign busy  = (state_q == S_RUN);
  assign done  = done_q;
  assign diff  = diff_q;
  assign bout  = bout_q;

endmodule
